// File: rtl/midi_voice_allocator.sv
// Polyphonic voice allocator: retrigger held note, else lowest free voice, else steal oldest.
// Optional sustain pedal support is enabled with `define MIDI_SUSTAIN_PEDAL_EN.
module midi_voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int AGE_BITS   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
`ifdef MIDI_SUSTAIN_PEDAL_EN
    input  logic                    sustain,
`endif
    input  logic                    ev_valid,
    output logic                    ev_ready,
    input  logic                    ev_note_on,
    input  logic [6:0]              ev_note,
    input  logic [6:0]              ev_vel,
    output logic [NUM_VOICES-1:0]   voice_gate,
    output logic [NUM_VOICES-1:0]   voice_trig,
    output logic [7*NUM_VOICES-1:0] voice_note,
    output logic [7*NUM_VOICES-1:0] voice_vel
);
    localparam int IDX_W = $clog2(NUM_VOICES);

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT, RELEASE} state_t;

    state_t                state_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic                  is_on_reg;
    logic [6:0]            note_reg;
    logic [6:0]            vel_reg;
    logic                  match_found_reg;
    logic [IDX_W-1:0]      match_idx_reg;
    logic                  free_found_reg;
    logic [IDX_W-1:0]      free_idx_reg;
    logic [IDX_W-1:0]      oldest_idx_reg;
    logic [AGE_BITS-1:0]   oldest_age_reg;
    logic [NUM_VOICES-1:0] off_mask_reg;
    logic [NUM_VOICES-1:0] gate_reg;
    logic [NUM_VOICES-1:0] trig_reg;
    logic [6:0]            note_arr [NUM_VOICES];
    logic [6:0]            vel_arr  [NUM_VOICES];
    logic [AGE_BITS-1:0]   age_arr  [NUM_VOICES];
    logic [IDX_W-1:0]      target;
    logic                  accept_ok;
`ifdef MIDI_SUSTAIN_PEDAL_EN
    logic                  sustain_prev_reg;
    logic                  sus_ev_reg;
    logic [NUM_VOICES-1:0] sustained_reg;

    // A pedal release seen in IDLE takes priority over a new event.
    assign accept_ok = !(sustain_prev_reg && !sustain);
`else
    assign accept_ok = 1'b1;
`endif

    assign ev_ready = (state_reg == IDLE) && accept_ok;

    always_comb begin
        target = oldest_idx_reg;
        if (match_found_reg)
            target = match_idx_reg;
        else if (free_found_reg)
            target = free_idx_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            idx_reg         <= '0;
            is_on_reg       <= 1'b0;
            note_reg        <= '0;
            vel_reg         <= '0;
            match_found_reg <= 1'b0;
            match_idx_reg   <= '0;
            free_found_reg  <= 1'b0;
            free_idx_reg    <= '0;
            oldest_idx_reg  <= '0;
            oldest_age_reg  <= '0;
            off_mask_reg    <= '0;
            gate_reg        <= '0;
            trig_reg        <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_arr[i] <= '0;
                vel_arr[i]  <= '0;
                age_arr[i]  <= '0;
            end
`ifdef MIDI_SUSTAIN_PEDAL_EN
            sustain_prev_reg <= 1'b0;
            sus_ev_reg       <= 1'b0;
            sustained_reg    <= '0;
`endif
        end else begin
            trig_reg <= '0;
            case (state_reg)
                IDLE: begin
`ifdef MIDI_SUSTAIN_PEDAL_EN
                    sustain_prev_reg <= sustain;
                    if (!accept_ok)
                        state_reg <= RELEASE;
                    else
`endif
                    if (ev_valid) begin
                        is_on_reg       <= ev_note_on && (ev_vel != 7'd0);
                        note_reg        <= ev_note;
                        vel_reg         <= ev_vel;
                        match_found_reg <= 1'b0;
                        free_found_reg  <= 1'b0;
                        off_mask_reg    <= '0;
                        idx_reg         <= '0;
`ifdef MIDI_SUSTAIN_PEDAL_EN
                        sus_ev_reg      <= sustain;
`endif
                        state_reg       <= SCAN;
                    end
                end
                SCAN: begin
                    if (gate_reg[idx_reg] && note_arr[idx_reg] == note_reg) begin
                        off_mask_reg[idx_reg] <= 1'b1;
                        if (!match_found_reg) begin
                            match_found_reg <= 1'b1;
                            match_idx_reg   <= idx_reg;
                        end
                    end
                    if (!gate_reg[idx_reg] && !free_found_reg) begin
                        free_found_reg <= 1'b1;
                        free_idx_reg   <= idx_reg;
                    end
                    // Strict greater-than keeps the lowest index on age ties.
                    if (idx_reg == '0 || age_arr[idx_reg] > oldest_age_reg) begin
                        oldest_idx_reg <= idx_reg;
                        oldest_age_reg <= age_arr[idx_reg];
                    end
                    if (idx_reg == IDX_W'(NUM_VOICES - 1))
                        state_reg <= COMMIT;
                    else
                        idx_reg <= idx_reg + 1'b1;
                end
                COMMIT: begin
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (is_on_reg) begin
                            if (i == int'(target)) begin
                                note_arr[i] <= note_reg;
                                vel_arr[i]  <= vel_reg;
                                age_arr[i]  <= '0;
                                gate_reg[i] <= 1'b1;
                                trig_reg[i] <= 1'b1;
`ifdef MIDI_SUSTAIN_PEDAL_EN
                                sustained_reg[i] <= 1'b0;
`endif
                            end else if (age_arr[i] != {AGE_BITS{1'b1}}) begin
                                age_arr[i] <= age_arr[i] + 1'b1;
                            end
                        end else if (off_mask_reg[i]) begin
`ifdef MIDI_SUSTAIN_PEDAL_EN
                            if (sus_ev_reg)
                                sustained_reg[i] <= 1'b1;
                            else
`endif
                            gate_reg[i] <= 1'b0;
                        end
                    end
                    state_reg <= IDLE;
                end
`ifdef MIDI_SUSTAIN_PEDAL_EN
                RELEASE: begin
                    gate_reg      <= gate_reg & ~sustained_reg;
                    sustained_reg <= '0;
                    state_reg     <= IDLE;
                end
`endif
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign voice_gate = gate_reg;
    assign voice_trig = trig_reg;

    generate
        for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_pack
            assign voice_note[7*gi +: 7] = note_arr[gi];
            assign voice_vel[7*gi +: 7]  = vel_arr[gi];
        end
    endgenerate
endmodule

// File: tb/tb_midi_voice_allocator.sv
// Directed bench for midi_voice_allocator (NUM_VOICES=4): allocation, stealing,
// note-off, retrigger, age saturation, mid-event reset, optional sustain pedal.
module tb_midi_voice_allocator;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ev_valid = 1'b0;
    logic        ev_ready;
    logic        ev_note_on = 1'b0;
    logic [6:0]  ev_note = '0;
    logic [6:0]  ev_vel = '0;
    logic [3:0]  voice_gate;
    logic [3:0]  voice_trig;
    logic [27:0] voice_note;
    logic [27:0] voice_vel;
`ifdef MIDI_SUSTAIN_PEDAL_EN
    logic        sustain = 1'b0;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    midi_voice_allocator #(.NUM_VOICES(4), .AGE_BITS(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef MIDI_SUSTAIN_PEDAL_EN
        .sustain    (sustain),
`endif
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_note_on (ev_note_on),
        .ev_note    (ev_note),
        .ev_vel     (ev_vel),
        .voice_gate (voice_gate),
        .voice_trig (voice_trig),
        .voice_note (voice_note),
        .voice_vel  (voice_vel)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] note_of(input int i);
        return voice_note[7*i +: 7];
    endfunction

    function automatic logic [6:0] vel_of(input int i);
        return voice_vel[7*i +: 7];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Issue one event, verify the 5-cycle busy window and the trig pulse on the
    // sample right after it. Garbage with ev_valid=1 is driven while busy.
    task automatic send(input logic on, input logic [6:0] n, input logic [6:0] v,
                        input logic [3:0] exp_trig);
        int w = 0;
        int lowc = 0;
        logic [3:0] trig_seen = '0;
        while (!ev_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("ready_wait", {31'd0, ev_ready}, 32'd1);
        ev_valid = 1'b1; ev_note_on = on; ev_note = n; ev_vel = v;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            if (!ev_ready) lowc++;
            trig_seen |= voice_trig;
            ev_valid = (c < 4);
            ev_note_on = ~on; ev_note = ~n; ev_vel = ~v;
            @(negedge clk);
        end
        ev_valid = 1'b0; ev_note_on = 1'b0; ev_note = '0; ev_vel = '0;
        check("busy_len", lowc, 32'd5);
        check("trig_busy", {28'd0, trig_seen}, 32'd0);
        check("trig", {28'd0, voice_trig}, {28'd0, exp_trig});
        check("ready_back", {31'd0, ev_ready}, 32'd1);
        $display("ev on=%0d note=%0d vel=%0d -> trig=%b gate=%b", on, n, v, voice_trig, voice_gate);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, ev_ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_gate", {28'd0, voice_gate}, 32'd0);
        check("rst_trig", {28'd0, voice_trig}, 32'd0);
        check("rst_note", {4'd0, voice_note}, 32'd0);
        check("rst_vel", {4'd0, voice_vel}, 32'd0);
        check("rst_ready2", {31'd0, ev_ready}, 32'd1);

        // Basic allocation into lowest free voices
        send(1'b1, 7'd60, 7'd100, 4'b0001);
        send(1'b1, 7'd64, 7'd90, 4'b0010);
        send(1'b1, 7'd67, 7'd80, 4'b0100);
        check("alloc_gate", {28'd0, voice_gate}, 32'h7);
        check("alloc_n0", {25'd0, note_of(0)}, 32'd60);
        check("alloc_n1", {25'd0, note_of(1)}, 32'd64);
        check("alloc_n2", {25'd0, note_of(2)}, 32'd67);
        check("alloc_v0", {25'd0, vel_of(0)}, 32'd100);
        check("alloc_v1", {25'd0, vel_of(1)}, 32'd90);
        check("alloc_v2", {25'd0, vel_of(2)}, 32'd80);

        // Steal: ages 3,2,1,0 -> voice 0 stolen
        do_reset();
        send(1'b1, 7'd60, 7'd10, 4'b0001);
        send(1'b1, 7'd62, 7'd10, 4'b0010);
        send(1'b1, 7'd64, 7'd10, 4'b0100);
        send(1'b1, 7'd65, 7'd10, 4'b1000);
        send(1'b1, 7'd67, 7'd50, 4'b0001);
        check("steal_gate", {28'd0, voice_gate}, 32'hf);
        check("steal_n0", {25'd0, note_of(0)}, 32'd67);
        check("steal_v0", {25'd0, vel_of(0)}, 32'd50);

        // Note-on with vel 0 releases 62 (voice 1); note-off of unheld note is a no-op
        send(1'b1, 7'd62, 7'd0, 4'b0000);
        check("off_gate", {28'd0, voice_gate}, 32'hd);
        check("off_n1_kept", {25'd0, note_of(1)}, 32'd62);
        send(1'b0, 7'd99, 7'd5, 4'b0000);
        check("noop_gate", {28'd0, voice_gate}, 32'hd);
        check("noop_notes", {4'd0, voice_note}, {4'd0, 7'd65, 7'd64, 7'd62, 7'd67});

        // Retrigger 64 in voice 2; ages become 1,4,0,2
        send(1'b1, 7'd64, 7'd20, 4'b0100);
        check("retrig_v2", {25'd0, vel_of(2)}, 32'd20);
        check("retrig_gate", {28'd0, voice_gate}, 32'hd);
        // Free voice 1 beats the older gated voices; ages 2,0,1,3
        send(1'b1, 7'd70, 7'd33, 4'b0010);
        check("free_n1", {25'd0, note_of(1)}, 32'd70);
        // Oldest is voice 3; ages 3,1,2,0
        send(1'b1, 7'd72, 7'd40, 4'b1000);
        check("old_n3", {25'd0, note_of(3)}, 32'd72);

        // 13 retriggers of voice 3: saturating ages 15,14,15 -> tie goes to voice 0
        for (int k = 0; k < 13; k++) send(1'b1, 7'd72, 7'd41, 4'b1000);
        send(1'b1, 7'd80, 7'd7, 4'b0001);
        check("sat_n0", {25'd0, note_of(0)}, 32'd80);
        check("sat_n2", {25'd0, note_of(2)}, 32'd64);

        // Explicit note-off (ev_note_on=0) of 70 in voice 1
        send(1'b0, 7'd70, 7'd64, 4'b0000);
        check("noteoff_gate", {28'd0, voice_gate}, 32'hd);

        // Reset mid-SCAN discards the event and clears outputs immediately
        ev_valid = 1'b1; ev_note_on = 1'b1; ev_note = 7'd90; ev_vel = 7'd9;
        @(negedge clk);
        ev_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_gate", {28'd0, voice_gate}, 32'd0);
        check("midrst_note", {4'd0, voice_note}, 32'd0);
        check("midrst_ready", {31'd0, ev_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("midrst_discard", {28'd0, voice_gate}, 32'd0);

`ifdef MIDI_SUSTAIN_PEDAL_EN
        send(1'b1, 7'd60, 7'd100, 4'b0001);
        sustain = 1'b1;
        @(negedge clk);
        send(1'b0, 7'd60, 7'd0, 4'b0000);
        check("sus_hold", {28'd0, voice_gate}, 32'h1);
        sustain = 1'b0;
        #1;
        check("sus_ready_low", {31'd0, ev_ready}, 32'd0);
        @(negedge clk);
        check("sus_release_state", {28'd0, voice_gate}, 32'h1);
        @(negedge clk);
        check("sus_cleared", {28'd0, voice_gate}, 32'h0);
        check("sus_ready_back", {31'd0, ev_ready}, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
